// File: rtl/tdec_pkg.sv
// Shared types and default parameters for the T flip-flop toggle decoder.
package tdec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    STUCK = 2'd2
  } tdec_state_e;

  localparam int unsigned CNT_W_DEF     = 8;
  localparam int unsigned RUN_W_DEF     = 6;
  localparam int unsigned STUCK_LIM_DEF = 16;

endpackage

// File: rtl/tdec_run_counter.sv
// Saturating count of non-toggling samples, plus a flag telling whether the
// next increment lands exactly on STUCK_LIM.
module tdec_run_counter
  import tdec_pkg::*;
#(
  parameter int unsigned RUN_W     = RUN_W_DEF,
  parameter int unsigned STUCK_LIM = STUCK_LIM_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             zero,
  output logic [RUN_W-1:0] run_len,
  output logic             hit_next
);

  logic [RUN_W-1:0] run_d, run_q;
  logic [RUN_W-1:0] run_inc;

  // hit_next depends only on the register so the parent's FSM logic sees no loop
  always_comb begin
    run_inc  = (run_q == '1) ? run_q : run_q + RUN_W'(1);
    hit_next = (run_inc == RUN_W'(STUCK_LIM));
    run_d    = run_q;
    if (clr || zero) begin
      run_d = '0;
    end else if (inc) begin
      run_d = run_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  assign run_len = run_q;

endmodule

// File: rtl/t_toggle_decoder.sv
// Recovers the T input of a T flip-flop from samples of its Q output.
// Define TDEC_REF_CHECK_EN to add the t_ref input and err_cnt mismatch counter.
module t_toggle_decoder
  import tdec_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned RUN_W     = RUN_W_DEF,
  parameter int unsigned STUCK_LIM = STUCK_LIM_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             q_in,
  output logic             t_out,
  output logic             t_valid,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [RUN_W-1:0] run_len,
  output logic             stuck
`ifdef TDEC_REF_CHECK_EN
  ,
  input  logic             t_ref,
  output logic [7:0]       err_cnt
`endif
);

  tdec_state_e      state_d, state_q;
  logic             q_prev_d, q_prev_q;
  logic             t_out_d, t_out_q;
  logic             t_valid_d, t_valid_q;
  logic             stuck_d, stuck_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             t_cur;
  logic             run_inc, run_zero, hit_next;
`ifdef TDEC_REF_CHECK_EN
  logic [7:0]       err_d, err_q;
`endif

  tdec_run_counter #(
    .RUN_W     (RUN_W),
    .STUCK_LIM (STUCK_LIM)
  ) u_run (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .inc      (run_inc),
    .zero     (run_zero),
    .run_len  (run_len),
    .hit_next (hit_next)
  );

  always_comb begin
    t_cur     = q_in ^ q_prev_q;
    state_d   = state_q;
    q_prev_d  = q_prev_q;
    t_out_d   = t_out_q;
    t_valid_d = 1'b0;
    cnt_d     = cnt_q;
    run_inc   = 1'b0;
    run_zero  = 1'b0;
`ifdef TDEC_REF_CHECK_EN
    err_d     = err_q;
`endif
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef TDEC_REF_CHECK_EN
      err_d   = '0;
`endif
    end else if (en) begin
      q_prev_d = q_in;
      if (state_q == IDLE) begin
        state_d = TRACK;
      end else begin
        t_out_d   = t_cur;
        t_valid_d = 1'b1;
        if (t_cur) begin
          cnt_d    = cnt_q + CNT_W'(1);
          run_zero = 1'b1;
          state_d  = TRACK;
        end else begin
          run_inc = 1'b1;
          if (hit_next) state_d = STUCK;
        end
`ifdef TDEC_REF_CHECK_EN
        if ((t_cur != t_ref) && (err_q != '1)) err_d = err_q + 8'd1;
`endif
      end
    end
    stuck_d = (state_d == STUCK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      q_prev_q  <= 1'b0;
      t_out_q   <= 1'b0;
      t_valid_q <= 1'b0;
      cnt_q     <= '0;
      stuck_q   <= 1'b0;
`ifdef TDEC_REF_CHECK_EN
      err_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      q_prev_q  <= q_prev_d;
      t_out_q   <= t_out_d;
      t_valid_q <= t_valid_d;
      cnt_q     <= cnt_d;
      stuck_q   <= stuck_d;
`ifdef TDEC_REF_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign t_out      = t_out_q;
  assign t_valid    = t_valid_q;
  assign toggle_cnt = cnt_q;
  assign stuck      = stuck_q;
`ifdef TDEC_REF_CHECK_EN
  assign err_cnt    = err_q;
`endif

endmodule
